// File: rtl/ex_mem_stage.sv
// Execute stage and EX/MEM pipeline register: operand forwarding, ALU, and result/control capture.
// Defining EX_MUL_EN adds an iterative 32-cycle shift-add multiplier for op 12 that stalls the front end.
module ex_mem_stage (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  aluOperation,
  input  logic [31:0] sigExt,
  input  logic [31:0] readData1,
  input  logic [31:0] readData2,
  input  logic        aluSrc,
  input  logic        regDst,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [3:0]  memWrite,
  input  logic        memToReg,
  input  logic [1:0]  memReadWidth,
  input  logic        regWrite,
  input  logic [1:0]  forwardA,
  input  logic [1:0]  forwardB,
  input  logic [31:0] wbData,
  output logic        stall,
  output logic [31:0] aluResultOut,
  output logic [31:0] writeDataOut,
  output logic [4:0]  writeRegOut,
  output logic [3:0]  memWriteOut,
  output logic        memToRegOut,
  output logic [1:0]  memReadWidthOut,
  output logic        regWriteOut
);

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_NOR  = 4'd5,
    OP_SLT  = 4'd6,
    OP_SLTU = 4'd7,
    OP_SLL  = 4'd8,
    OP_SRL  = 4'd9,
    OP_SRA  = 4'd10,
    OP_LUI  = 4'd11,
    OP_MUL  = 4'd12
  } aluOp_e;

  logic [31:0] fwdA;
  logic [31:0] fwdB;
  logic [31:0] opB;
  logic [31:0] aluResult;
  logic        stallMul;
  logic        mulDone;
  logic [31:0] mulResult;

  // Forward select 11 is unused by the hazard unit and falls back to the register value.
  always_comb begin
    fwdA = readData1;
    fwdB = readData2;
    case (forwardA)
      2'b01:   fwdA = wbData;
      2'b10:   fwdA = aluResultOut;
      default: fwdA = readData1;
    endcase
    case (forwardB)
      2'b01:   fwdB = wbData;
      2'b10:   fwdB = aluResultOut;
      default: fwdB = readData2;
    endcase
  end

  assign opB = aluSrc ? sigExt : fwdB;

  always_comb begin
    aluResult = 32'd0;
    case (aluOperation)
      OP_ADD:  aluResult = fwdA + opB;
      OP_SUB:  aluResult = fwdA - opB;
      OP_AND:  aluResult = fwdA & opB;
      OP_OR:   aluResult = fwdA | opB;
      OP_XOR:  aluResult = fwdA ^ opB;
      OP_NOR:  aluResult = ~(fwdA | opB);
      OP_SLT:  aluResult = {31'd0, $signed(fwdA) < $signed(opB)};
      OP_SLTU: aluResult = {31'd0, fwdA < opB};
      OP_SLL:  aluResult = opB << fwdA[4:0];
      OP_SRL:  aluResult = opB >> fwdA[4:0];
      OP_SRA:  aluResult = $signed(opB) >>> fwdA[4:0];
      OP_LUI:  aluResult = opB << 16;
      default: aluResult = 32'd0;
    endcase
  end

`ifdef EX_MUL_EN
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mulState_e;

  mulState_e   state_q, state_d;
  logic [31:0] mcand_q, mcand_d;
  logic [31:0] mplier_q, mplier_d;
  logic [31:0] product_q, product_d;
  logic [4:0]  count_q, count_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      mcand_q   <= 32'd0;
      mplier_q  <= 32'd0;
      product_q <= 32'd0;
      count_q   <= 5'd0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      product_q <= product_d;
      count_q   <= count_d;
    end
  end

  // Operands are captured once on detection; later forward selects no longer matter.
  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    product_d = product_q;
    count_d   = count_q;
    stallMul  = 1'b0;
    case (state_q)
      IDLE: begin
        if (aluOperation == OP_MUL) begin
          stallMul  = 1'b1;
          mcand_d   = fwdA;
          mplier_d  = opB;
          product_d = 32'd0;
          count_d   = 5'd0;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        stallMul = 1'b1;
        if (mplier_q[0]) begin
          product_d = product_q + mcand_q;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        count_d  = count_q + 5'd1;
        if (count_q == 5'd31) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign mulDone   = (state_q == DONE);
  assign mulResult = product_q;
`else
  assign stallMul  = 1'b0;
  assign mulDone   = 1'b0;
  assign mulResult = 32'd0;
`endif

  assign stall = stallMul & ~reset;

  logic [31:0] aluResult_q, aluResult_d;
  logic [31:0] writeData_q, writeData_d;
  logic [4:0]  writeReg_q, writeReg_d;
  logic [3:0]  memWrite_q, memWrite_d;
  logic        memToReg_q, memToReg_d;
  logic [1:0]  memReadWidth_q, memReadWidth_d;
  logic        regWrite_q, regWrite_d;

  // A stalled cycle sends a bubble down to MEM so the held instruction is not issued twice.
  always_comb begin
    aluResult_d    = 32'd0;
    writeData_d    = 32'd0;
    writeReg_d     = 5'd0;
    memWrite_d     = 4'd0;
    memToReg_d     = 1'b0;
    memReadWidth_d = 2'd0;
    regWrite_d     = 1'b0;
    if (!stall) begin
      aluResult_d    = mulDone ? mulResult : aluResult;
      writeData_d    = fwdB;
      writeReg_d     = regDst ? rd : rt;
      memWrite_d     = memWrite;
      memToReg_d     = memToReg;
      memReadWidth_d = memReadWidth;
      regWrite_d     = regWrite;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      aluResult_q    <= 32'd0;
      writeData_q    <= 32'd0;
      writeReg_q     <= 5'd0;
      memWrite_q     <= 4'd0;
      memToReg_q     <= 1'b0;
      memReadWidth_q <= 2'd0;
      regWrite_q     <= 1'b0;
    end else begin
      aluResult_q    <= aluResult_d;
      writeData_q    <= writeData_d;
      writeReg_q     <= writeReg_d;
      memWrite_q     <= memWrite_d;
      memToReg_q     <= memToReg_d;
      memReadWidth_q <= memReadWidth_d;
      regWrite_q     <= regWrite_d;
    end
  end

  assign aluResultOut    = aluResult_q;
  assign writeDataOut    = writeData_q;
  assign writeRegOut     = writeReg_q;
  assign memWriteOut     = memWrite_q;
  assign memToRegOut     = memToReg_q;
  assign memReadWidthOut = memReadWidth_q;
  assign regWriteOut     = regWrite_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed testbench for ex_mem_stage; multiplier scenarios run only when EX_MUL_EN is defined.
module tb_ex_mem_stage;

  logic        clock;
  logic        reset;
  logic [3:0]  aluOperation;
  logic [31:0] sigExt, readData1, readData2, wbData;
  logic        aluSrc, regDst, memToReg, regWrite;
  logic [4:0]  rt, rd;
  logic [3:0]  memWrite;
  logic [1:0]  memReadWidth, forwardA, forwardB;
  logic        stall;
  logic [31:0] aluResultOut, writeDataOut;
  logic [4:0]  writeRegOut;
  logic [3:0]  memWriteOut;
  logic        memToRegOut;
  logic [1:0]  memReadWidthOut;
  logic        regWriteOut;

  int total = 0;
  int bad   = 0;

  ex_mem_stage dut (
    .clock(clock), .reset(reset), .aluOperation(aluOperation),
    .sigExt(sigExt), .readData1(readData1), .readData2(readData2),
    .aluSrc(aluSrc), .regDst(regDst), .rt(rt), .rd(rd),
    .memWrite(memWrite), .memToReg(memToReg), .memReadWidth(memReadWidth),
    .regWrite(regWrite), .forwardA(forwardA), .forwardB(forwardB),
    .wbData(wbData), .stall(stall), .aluResultOut(aluResultOut),
    .writeDataOut(writeDataOut), .writeRegOut(writeRegOut),
    .memWriteOut(memWriteOut), .memToRegOut(memToRegOut),
    .memReadWidthOut(memReadWidthOut), .regWriteOut(regWriteOut)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Drives a plain register-register instruction writing rd with no memory access.
  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    aluOperation = op;
    readData1    = a;
    readData2    = b;
    sigExt       = 32'h0000_0000;
    aluSrc       = 1'b0;
    regDst       = 1'b1;
    rt           = 5'd2;
    rd           = 5'd3;
    memWrite     = 4'd0;
    memToReg     = 1'b0;
    memReadWidth = 2'd0;
    regWrite     = 1'b1;
    forwardA     = 2'b00;
    forwardB     = 2'b00;
    wbData       = 32'h0;
  endtask

  task automatic stepClock();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    applyStimulus(4'd0, 32'd1, 32'd1);
    reset = 1'b1;
    #3;
    total++;
    if (aluResultOut !== 32'd0) begin bad++; $display("[TB] FAIL reset_alu got=%h want=0", aluResultOut); end
    total++;
    if ({regWriteOut, memWriteOut, memToRegOut, writeRegOut, memReadWidthOut} !== 13'd0) begin
      bad++; $display("[TB] FAIL reset_ctrl got=%b want=0", {regWriteOut, memWriteOut, memToRegOut, writeRegOut, memReadWidthOut});
    end
    total++;
    if (writeDataOut !== 32'd0) begin bad++; $display("[TB] FAIL reset_wdata got=%h want=0", writeDataOut); end
    total++;
    if (stall !== 1'b0) begin bad++; $display("[TB] FAIL reset_stall got=%b want=0", stall); end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_add();
    applyStimulus(4'd0, 32'd5, 32'd7);
    stepClock();
    total++;
    if (aluResultOut !== 32'd12) begin bad++; $display("[TB] FAIL add_result got=%0d want=12", aluResultOut); end
    total++;
    if (writeRegOut !== 5'd3) begin bad++; $display("[TB] FAIL add_wreg got=%0d want=3", writeRegOut); end
    total++;
    if (regWriteOut !== 1'b1) begin bad++; $display("[TB] FAIL add_regwrite got=%b want=1", regWriteOut); end
    total++;
    if (writeDataOut !== 32'd7) begin bad++; $display("[TB] FAIL add_wdata got=%0d want=7", writeDataOut); end
  endtask

  task automatic test_forwarding();
    applyStimulus(4'd0, 32'd60, 32'd40);
    stepClock();
    total++;
    if (aluResultOut !== 32'd100) begin bad++; $display("[TB] FAIL fwd_setup got=%0d want=100", aluResultOut); end
    applyStimulus(4'd0, 32'd999, 32'd55);
    forwardA = 2'b10;
    aluSrc   = 1'b1;
    sigExt   = 32'd4;
    forwardB = 2'b01;
    wbData   = 32'h0000_DEAD;
    stepClock();
    total++;
    if (aluResultOut !== 32'd104) begin bad++; $display("[TB] FAIL fwd_exmem got=%0d want=104", aluResultOut); end
    total++;
    if (writeDataOut !== 32'h0000_DEAD) begin bad++; $display("[TB] FAIL fwd_wb_store got=%h want=0000dead", writeDataOut); end
    applyStimulus(4'd0, 32'd1, 32'd50);
    forwardA = 2'b11;
    forwardB = 2'b11;
    wbData   = 32'd1000;
    regDst   = 1'b0;
    stepClock();
    total++;
    if (aluResultOut !== 32'd51) begin bad++; $display("[TB] FAIL fwd_sel11 got=%0d want=51", aluResultOut); end
    total++;
    if (writeRegOut !== 5'd2) begin bad++; $display("[TB] FAIL regdst_rt got=%0d want=2", writeRegOut); end
  endtask

  task automatic test_alu_ops();
    logic [3:0]  ops [14] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd8, 4'd9, 4'd10, 4'd11, 4'd0, 4'd13};
    logic [31:0] as  [14] = '{32'h0, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'h0F0F0000, 32'hFFFFFFFF, 32'hFFFFFFFF,
                              32'd4, 32'h3F, 32'd4, 32'd4, 32'hABCD, 32'hFFFFFFFF, 32'd9};
    logic [31:0] bs  [14] = '{32'd1, 32'h0FF00FF0, 32'h0FF00FF0, 32'h0FF00FF0, 32'h00F0000F, 32'd1, 32'd1,
                              32'd1, 32'd1, 32'h80000000, 32'h80000000, 32'h1234, 32'd2, 32'd9};
    logic [31:0] es  [14] = '{32'hFFFFFFFF, 32'h00F000F0, 32'hFFF0FFF0, 32'hFF00FF00, 32'hF000FFF0, 32'd1, 32'd0,
                              32'h10, 32'h80000000, 32'h08000000, 32'hF8000000, 32'h12340000, 32'd1, 32'd0};
    for (int i = 0; i < 14; i++) begin
      applyStimulus(ops[i], as[i], bs[i]);
      #1;
      total++;
      if (stall !== 1'b0) begin bad++; $display("[TB] FAIL alu_stall[%0d] got=%b want=0", i, stall); end
      stepClock();
      total++;
      if (aluResultOut !== es[i]) begin
        bad++; $display("[TB] FAIL alu_op%0d[%0d] got=%h want=%h", ops[i], i, aluResultOut, es[i]);
      end
    end
  endtask

  task automatic test_controls();
    applyStimulus(4'd0, 32'd10, 32'h1111_2222);
    aluSrc       = 1'b1;
    sigExt       = 32'd8;
    memWrite     = 4'b1100;
    memToReg     = 1'b1;
    memReadWidth = 2'd2;
    regWrite     = 1'b0;
    stepClock();
    total++;
    if (aluResultOut !== 32'd18) begin bad++; $display("[TB] FAIL ctrl_addr got=%0d want=18", aluResultOut); end
    total++;
    if (writeDataOut !== 32'h1111_2222) begin bad++; $display("[TB] FAIL ctrl_store got=%h want=11112222", writeDataOut); end
    total++;
    if ({memWriteOut, memToRegOut, memReadWidthOut, regWriteOut} !== 8'b1100_1_10_0) begin
      bad++; $display("[TB] FAIL ctrl_pass got=%b want=11001100", {memWriteOut, memToRegOut, memReadWidthOut, regWriteOut});
    end
  endtask

`ifdef EX_MUL_EN
  // Runs one multiply already presented on the inputs; expects 33 stall cycles then the product.
  task automatic test_mul_run(input string tag, input logic [31:0] want, input logic corruptA);
    int n = 0;
    #1;
    while (stall === 1'b1 && n < 50) begin
      n++;
      stepClock();
      if (corruptA) readData1 = 32'h7;
      total++;
      if (regWriteOut !== 1'b0 || aluResultOut !== 32'd0) begin
        bad++; $display("[TB] FAIL %s_bubble cyc=%0d regWrite=%b result=%h want 0/0", tag, n, regWriteOut, aluResultOut);
      end
    end
    total++;
    if (n !== 33) begin bad++; $display("[TB] FAIL %s_stall_len got=%0d want=33", tag, n); end
    stepClock();
    total++;
    if (aluResultOut !== want) begin bad++; $display("[TB] FAIL %s_result got=%h want=%h", tag, aluResultOut, want); end
    total++;
    if (regWriteOut !== 1'b1 || writeRegOut !== 5'd3) begin
      bad++; $display("[TB] FAIL %s_ctrl regWrite=%b wreg=%0d want 1/3", tag, regWriteOut, writeRegOut);
    end
  endtask

  task automatic test_mul();
    applyStimulus(4'd12, 32'h0001_0003, 32'd5);
    test_mul_run("mul", 32'h0005_000F, 1'b1);
  endtask

  task automatic test_back_to_back();
    applyStimulus(4'd12, 32'hFFFF_FFFD, 32'd6);
    test_mul_run("mul_b2b_a", 32'hFFFF_FFEE, 1'b0);
    applyStimulus(4'd12, 32'd7, 32'd6);
    test_mul_run("mul_b2b_b", 32'd42, 1'b0);
    applyStimulus(4'd0, 32'd1, 32'd2);
    #1;
    total++;
    if (stall !== 1'b0) begin bad++; $display("[TB] FAIL mul_after_stall got=%b want=0", stall); end
    stepClock();
  endtask

  task automatic test_reset_mid_mul();
    applyStimulus(4'd12, 32'h0001_0003, 32'd5);
    for (int i = 0; i < 10; i++) stepClock();
    reset = 1'b1;
    #1;
    total++;
    if (stall !== 1'b0) begin bad++; $display("[TB] FAIL midreset_stall got=%b want=0", stall); end
    total++;
    if (aluResultOut !== 32'd0 || regWriteOut !== 1'b0) begin
      bad++; $display("[TB] FAIL midreset_out result=%h regWrite=%b want 0/0", aluResultOut, regWriteOut);
    end
    @(negedge clock);
    reset = 1'b0;
    test_mul_run("mul_after_reset", 32'h0005_000F, 1'b0);
  endtask
`else
  task automatic test_mul_disabled();
    applyStimulus(4'd12, 32'd3, 32'd5);
    #1;
    total++;
    if (stall !== 1'b0) begin bad++; $display("[TB] FAIL nomul_stall got=%b want=0", stall); end
    stepClock();
    total++;
    if (aluResultOut !== 32'd0) begin bad++; $display("[TB] FAIL nomul_result got=%h want=0", aluResultOut); end
    total++;
    if (regWriteOut !== 1'b1 || stall !== 1'b0) begin
      bad++; $display("[TB] FAIL nomul_ctrl regWrite=%b stall=%b want 1/0", regWriteOut, stall);
    end
  endtask
`endif

  initial begin
    reset = 1'b1;
    applyStimulus(4'd0, 32'd0, 32'd0);
    test_reset();
    test_add();
    test_forwarding();
    test_alu_ops();
    test_controls();
`ifdef EX_MUL_EN
    test_mul();
    test_back_to_back();
    test_reset_mid_mul();
`else
    test_mul_disabled();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
